// File: rtl/pkg_mult.sv
// Shared types and constants for the sequential shift-add multiplier.
// DW sets the operand width and hence the number of calculate steps.
package pkg_mult;

    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    typedef logic [CW-1:0] count_t;

endpackage

// File: rtl/start_edge.sv
// Rising-edge one-shot for the start button.
// The history register resets high, so a button held through reset is ignored.
module start_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_pulse = i_sig & ~r_prev;

endmodule

// File: rtl/mult_ctrl.sv
// Control FSM for the shift-add multiplier: one load pulse, DW calc steps, then stop.
// Define MULT_START_EDGE_EN to start on a rising edge of i_start instead of its level.
module mult_ctrl #(
    parameter  int DW = pkg_mult::DW,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_clear,
    output logic          o_load,
    output logic          o_calc_en,
    output logic [CW-1:0] o_count,
    output logic          o_busy,
    output logic          o_stop
);

    import pkg_mult::*;

    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic          w_start;
    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_load;
    logic          r_calc_en;
    logic          r_busy;
    logic          r_stop;

`ifdef MULT_START_EDGE_EN
    start_edge u_start_edge (
        .clk     (clk),
        .rst     (rst),
        .i_sig   (i_start),
        .o_pulse (w_start)
    );
`else
    assign w_start = i_start;
`endif

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_load    <= 1'b0;
            r_calc_en <= 1'b0;
            r_busy    <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_state <= LOAD;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_stop  <= 1'b0;
                    end
                end
                LOAD: begin
                    r_state   <= CALC;
                    r_count   <= '0;
                    r_load    <= 1'b0;
                    r_calc_en <= 1'b1;
                end
                CALC: begin
                    if (r_count == LAST) begin
                        r_state   <= DONE;
                        r_count   <= '0;
                        r_calc_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_stop    <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_load    = r_load;
    assign o_calc_en = r_calc_en;
    assign o_count   = r_count;
    assign o_busy    = r_busy;
    assign o_stop    = r_stop;

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: cycle model plus directed scenarios.
// Build with MULT_START_EDGE_EN defined to exercise the edge-start variant.
module tb_mult_ctrl;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_clear = 1'b0;
    logic       o_load;
    logic       o_calc_en;
    logic [3:0] o_count;
    logic       o_busy;
    logic       o_stop;

    int n_chk = 0;
    int n_err = 0;
    int n_load = 0;

    mult_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_clear   (i_clear),
        .o_load    (o_load),
        .o_calc_en (o_calc_en),
        .o_count   (o_count),
        .o_busy    (o_busy),
        .o_stop    (o_stop)
    );

    always #5 clk = ~clk;

    // Model: m_t = cycles since the load cycle (-1 when not running).
    int   m_t = -1;
    bit   m_done = 0;
    bit   m_prev = 1;
    bit   m_valid = 0;

    always @(posedge clk) begin
        bit req;
`ifdef MULT_START_EDGE_EN
        req = i_start && !m_prev;
`else
        req = i_start;
`endif
        m_prev = i_start;
        if (rst) begin
            m_t = -1;
            m_done = 0;
            m_prev = 1;
            m_valid = 1;
        end else if (i_clear) begin
            m_t = -1;
            m_done = 0;
        end else if (m_t >= 0) begin
            m_t = m_t + 1;
            if (m_t == DW + 1) begin
                m_t = -1;
                m_done = 1;
            end
        end else if (req) begin
            m_t = 0;
            m_done = 0;
        end
    end

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            int ec;
            ec = (m_t >= 1 && m_t <= DW) ? m_t - 1 : 0;
            chk("m_load", int'(o_load), int'(m_t == 0));
            chk("m_calc", int'(o_calc_en), int'(m_t >= 1 && m_t <= DW));
            chk("m_count", int'(o_count), ec);
            chk("m_busy", int'(o_busy), int'(m_t >= 0));
            chk("m_stop", int'(o_stop), int'(m_done));
        end
        if (o_load) n_load++;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_count(int v, string name);
        int k;
        k = 0;
        while (!(o_calc_en && o_count == 4'(v)) && k < 20) begin
            tick(1);
            k++;
        end
        chk(name, int'(o_count == 4'(v)), 1);
    endtask

    task automatic wait_stop(string name);
        int k;
        k = 0;
        while (!o_stop && k < 20) begin
            tick(1);
            k++;
        end
        chk(name, int'(o_stop), 1);
    endtask

    initial begin
        // Reset with start held high.
        rst = 1'b1;
        i_start = 1'b1;
        tick(1);
        @(negedge clk);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_stop", int'(o_stop), 0);
        tick(1);
        rst = 1'b0;
`ifdef MULT_START_EDGE_EN
        tick(3);
        chk("held_no_run", int'(o_busy || o_load), 0);
`endif
        i_start = 1'b0;
        tick(2);
        chk("idle_count", int'(o_count), 0);

        // Normal run from a one-cycle start pulse.
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        chk("run_load_k1", int'(o_load), 1);
        chk("run_calc_k1", int'(o_calc_en), 0);
        tick(1);
        chk("run_load_k2", int'(o_load), 0);
        chk("run_cnt_k2", int'(o_count), 0);
        tick(7);
        chk("run_cnt_k9", int'(o_count), 7);
        chk("run_stop_k9", int'(o_stop), 0);
        tick(1);
        chk("run_stop_k10", int'(o_stop), 1);
        chk("run_calc_k10", int'(o_calc_en), 0);
        tick(5);
        chk("run_stop_held", int'(o_stop), 1);

        // Clear at count 3 aborts the run.
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_count(3, "clr_reach3");
        i_clear = 1'b1;
        tick(1);
        i_clear = 1'b0;
        chk("clr_calc", int'(o_calc_en), 0);
        chk("clr_count", int'(o_count), 0);
        chk("clr_busy", int'(o_busy), 0);
        tick(12);
        chk("clr_no_stop", int'(o_stop), 0);

        // Start and clear together from DONE.
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_stop("sc_reach_done");
        i_start = 1'b1;
        i_clear = 1'b1;
        tick(1);
        i_start = 1'b0;
        i_clear = 1'b0;
        chk("sc_stop", int'(o_stop), 0);
        chk("sc_load", int'(o_load), 0);
        tick(1);
        chk("sc_load2", int'(o_load), 0);

        // Start during CALC is ignored.
        n_load = 0;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_count(5, "ign_reach5");
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        tick(1);
        chk("ign_cnt7", int'(o_count), 7);
        tick(1);
        chk("ign_stop", int'(o_stop), 1);
        tick(3);
        chk("ign_loads", n_load, 1);

        // Held start for 30 cycles from DONE.
        n_load = 0;
        i_start = 1'b1;
        tick(30);
        i_start = 1'b0;
        tick(12);
`ifdef MULT_START_EDGE_EN
        chk("held_loads", n_load, 1);
`else
        chk("held_loads", n_load, 3);
`endif
        chk("held_stop", int'(o_stop), 1);

        // Reset mid-run.
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_busy", int'(o_busy), 0);
        tick(12);
        chk("mid_rst_stop", int'(o_stop), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
